multi_clock_divider: RTL and testbench
======================================

MULTI_CLOCK_DIVIDER -- requirements
Module: multi_clock_divider

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 26: divider counter width per channel.
REQ-003 SHALL have parameter DIV_INIT, default 1000000: per-channel divide value loaded at reset.
REQ-004 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port run  input  CH  per-channel count enable; 1 = count, 0 = freeze.
REQ-007 SHALL have port ld_valid  input  1  one-cycle configuration write strobe.
REQ-008 SHALL have port ld_ch  input  $clog2(CH) (min 1)  channel index for the write.
REQ-009 SHALL have port ld_div  input  CNT_W  new divide value; period = ld_div+1 cycles.
REQ-010 SHALL have port ld_mode  input  2  new output mode: 0 TOGGLE, 1 PULSE, 2 PWM, 3 reserved.
REQ-011 SHALL have port ld_duty  input  CNT_W  PWM high-time in cycles; ignored unless PWM is compiled in.
REQ-012 SHALL have port tick  output  CH  registered one-cycle strobe per channel period.
REQ-013 SHALL have port wave  output  CH  registered per-channel waveform selected by mode.

Function
REQ-014 Each channel SHALL hold registers div, mode, duty, and count (CNT_W bits).
REQ-015 With run[i]=1, count[i] SHALL increment each cycle and wrap to 0 in the cycle after it equals div[i].
REQ-016 tick[i] SHALL be 1 in exactly the cycle after count[i]==div[i] with run[i]=1, and 0 otherwise.
REQ-017 After reset release with run=1, the first tick SHALL occur div+1 cycles after the first rising edge; later ticks SHALL follow every div+1 cycles.
REQ-018 div=0 SHALL assert tick every cycle.
REQ-019 In TOGGLE mode, wave[i] SHALL invert in the same cycle tick[i] asserts, giving period 2*(div+1) at 50% duty.
REQ-020 In PULSE mode, wave[i] SHALL equal tick[i].
REQ-021 In mode 3, wave[i] SHALL be held at 0; tick still operates.
REQ-022 With run[i]=0, count[i] and wave[i] SHALL hold their values and tick[i] SHALL be 0.
REQ-023 Releasing run SHALL resume counting from the held count, with no extra or lost tick.
REQ-024 When ld_valid=1, channel ld_ch SHALL capture div, mode and duty at that edge, and also set count=0, tick=0 and wave=0.
REQ-025 The first tick after a write SHALL follow REQ-017 timing, measured from the write edge.
REQ-026 If a write coincides with the channel's terminal count, the write SHALL win and no tick is emitted.
REQ-027 An ld_ch value >= CH SHALL be ignored with no state change.
REQ-028 Channels other than ld_ch SHALL be unaffected by a write.

Reset
REQ-029 While RESET=1, every channel SHALL hold count=0, div=DIV_INIT, mode=TOGGLE, duty=0, tick=0, wave=0.
REQ-030 Reset assertion mid-period SHALL clear all state immediately, without waiting for CLK.
REQ-031 Deassertion SHALL be taken synchronously to CLK by the instantiating design; no internal synchroniser SHALL be present.

Configuration
REQ-032 The macro MULTI_CLOCK_DIVIDER_PWM_EN SHALL compile the PWM feature in or out.
REQ-033 With MULTI_CLOCK_DIVIDER_PWM_EN defined, PWM mode SHALL set wave[i]=1 while count[i] < duty[i], and 0 otherwise.
REQ-034 In PWM mode, duty=0 SHALL give constant 0 and duty > div SHALL give constant 1.
REQ-035 Without MULTI_CLOCK_DIVIDER_PWM_EN, the duty registers SHALL not exist, ld_duty SHALL be ignored, and mode 2 SHALL behave as mode 3.

Structure
REQ-036 Package mcd_pkg SHALL hold the mode enum (MODE_TOGGLE, MODE_PULSE, MODE_PWM, MODE_RSVD) and the mode width constant.
REQ-037 Sub-module mcd_channel SHALL implement one channel's registers and counter, and SHALL be instantiated CH times by a generate loop.
REQ-038 The top level SHALL contain only write decode and the per-channel instances.

Verification
REQ-039 CH=4, DIV_INIT=3, run=4'hF, reset released -> tick on every 4th cycle, and wave toggles with period 8 on all channels.
REQ-040 Write ch2 div=0 mode=PULSE -> tick[2]=wave[2]=1 every cycle from the cycle after the write; ch0, ch1 and ch3 keep their phase.
REQ-041 Write ch1 div=9 at the edge where count==3 -> no tick at the old terminal count; next tick[1] follows 10 cycles after the write edge.
REQ-042 Drop run[0] for 5 cycles mid-period with div=3 -> tick[0] is delayed exactly 5 cycles, and wave[0] holds its value.
REQ-043 With PWM_EN, write ch3 div=9 duty=3 mode=PWM -> wave[3] is high 3 of every 10 cycles; duty=0 gives all low; duty=12 gives all high.
REQ-044 Assert RESET asynchronously mid-period -> all outputs are 0 before the next CLK edge, and the REQ-039 sequence restarts after release.

Source files
------------

// File: rtl/multi_clock_divider_pkg.sv
// Shared types for the multi-channel clock divider.
// Build option: MULTI_CLOCK_DIVIDER_PWM_EN adds the PWM output mode and duty registers.
package mcd_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_TOGGLE = 2'd0,
        MODE_PULSE  = 2'd1,
        MODE_PWM    = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

endpackage

// File: rtl/multi_clock_divider_if.sv
// Configuration write bus shared by all divider channels. The per-channel
// write strobe is decoded by the top and handed to each channel separately.
// Build option: MULTI_CLOCK_DIVIDER_PWM_EN adds the duty field.
interface multi_clock_divider_if #(
    parameter int CNT_W = 26
);
    import mcd_pkg::*;

    logic [CNT_W-1:0]  div;
    logic [MODE_W-1:0] mode;
`ifdef MULTI_CLOCK_DIVIDER_PWM_EN
    logic [CNT_W-1:0]  duty;

    modport master (output div, mode, duty);
    modport slave  (input  div, mode, duty);
`else
    modport master (output div, mode);
    modport slave  (input  div, mode);
`endif

endinterface

// File: rtl/multi_clock_divider_channel.sv
// One divider channel: period counter, registered tick strobe and the
// mode-selected waveform. A write reloads the configuration and restarts
// the period, and takes priority over a coincident terminal count.
// Build option: MULTI_CLOCK_DIVIDER_PWM_EN enables PWM mode and the duty register.
module mcd_channel
    import mcd_pkg::*;
#(
    parameter int CNT_W    = 26,
    parameter int DIV_INIT = 1000000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  run_i,
    input  logic                  wr_i,
    multi_clock_divider_if.slave  ld_if,
    output logic                  tick_o,
    output logic                  wave_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_q;
    mode_e            mode_q;
    logic             tick_q, tick_d;
    logic             wave_q, wave_d;
    logic             term;
`ifdef MULTI_CLOCK_DIVIDER_PWM_EN
    logic [CNT_W-1:0] duty_q;
`endif

    // Next count, tick and wave; a frozen channel keeps its wave and drops tick.
    always_comb begin
        term    = (count_q == div_q);
        count_d = term ? '0 : count_q + 1'b1;
        tick_d  = run_i & term;
        wave_d  = wave_q;
        if (run_i) begin
            case (mode_q)
                MODE_TOGGLE: wave_d = wave_q ^ term;
                MODE_PULSE:  wave_d = term;
`ifdef MULTI_CLOCK_DIVIDER_PWM_EN
                // Compared against the new count so wave lines up with count_q.
                MODE_PWM:    wave_d = (count_d < duty_q);
`endif
                default:     wave_d = 1'b0;
            endcase
        end
    end

    // Channel state: reset, configuration write, then normal counting.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            div_q   <= CNT_W'(DIV_INIT);
            mode_q  <= MODE_TOGGLE;
            tick_q  <= 1'b0;
            wave_q  <= 1'b0;
`ifdef MULTI_CLOCK_DIVIDER_PWM_EN
            duty_q  <= '0;
`endif
        end else if (wr_i) begin
            count_q <= '0;
            div_q   <= ld_if.div;
            mode_q  <= mode_e'(ld_if.mode);
            tick_q  <= 1'b0;
            wave_q  <= 1'b0;
`ifdef MULTI_CLOCK_DIVIDER_PWM_EN
            duty_q  <= ld_if.duty;
`endif
        end else begin
            tick_q <= tick_d;
            wave_q <= wave_d;
            if (run_i) begin
                count_q <= count_d;
            end
        end
    end

    assign tick_o = tick_q;
    assign wave_o = wave_q;

endmodule

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider: write decode plus CH channel
// instances. Out-of-range channel indices match no channel and are dropped.
// Build option: MULTI_CLOCK_DIVIDER_PWM_EN enables PWM mode (duty input used).
module multi_clock_divider
    import mcd_pkg::*;
#(
    parameter int  CH       = 4,
    parameter int  CNT_W    = 26,
    parameter int  DIV_INIT = 1000000,
    localparam int CH_W     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [CH-1:0]     run,
    input  logic              ld_valid,
    input  logic [CH_W-1:0]   ld_ch,
    input  logic [CNT_W-1:0]  ld_div,
    input  logic [MODE_W-1:0] ld_mode,
    input  logic [CNT_W-1:0]  ld_duty,
    output logic [CH-1:0]     tick,
    output logic [CH-1:0]     wave
);

    multi_clock_divider_if #(.CNT_W(CNT_W)) ld_bus ();

    assign ld_bus.div  = ld_div;
    assign ld_bus.mode = ld_mode;
`ifdef MULTI_CLOCK_DIVIDER_PWM_EN
    assign ld_bus.duty = ld_duty;
`else
    logic unused_duty;
    assign unused_duty = ^ld_duty;
`endif

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic wr;
        assign wr = ld_valid && (ld_ch == CH_W'(gi));

        mcd_channel #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .clk_i  (CLK),
            .rst_i  (RESET),
            .run_i  (run[gi]),
            .wr_i   (wr),
            .ld_if  (ld_bus.slave),
            .tick_o (tick[gi]),
            .wave_o (wave[gi])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Scoreboard bench for multi_clock_divider: the driver updates a period/tick
// counting model and queues expected outputs; a monitor checks them.
// Build option: MULTI_CLOCK_DIVIDER_PWM_EN switches the model to PWM behaviour.
module tb_multi_clock_divider;
    import mcd_pkg::*;

    localparam int CH       = 4;
    localparam int CNT_W    = 8;
    localparam int DIV_INIT = 3;
`ifdef MULTI_CLOCK_DIVIDER_PWM_EN
    localparam bit PWM = 1'b1;
`else
    localparam bit PWM = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RESET;
    logic [CH-1:0]    run;
    logic             ld_valid;
    logic [1:0]       ld_ch;
    logic [CNT_W-1:0] ld_duty;
    logic [CH-1:0]    tick, wave;

    multi_clock_divider_if #(.CNT_W(CNT_W)) bus ();

    multi_clock_divider #(.CH(CH), .CNT_W(CNT_W), .DIV_INIT(DIV_INIT)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .run      (run),
        .ld_valid (ld_valid),
        .ld_ch    (ld_ch),
        .ld_div   (bus.div),
        .ld_mode  (bus.mode),
        .ld_duty  (ld_duty),
        .tick     (tick),
        .wave     (wave)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [CH-1:0] tick;
        logic [CH-1:0] wave;
    } exp_t;
    exp_t q[$];

    int total = 0;
    int bad   = 0;

    // Model: per channel, run-enabled edges since load and ticks since load.
    int m_div[CH], m_mode[CH], m_duty[CH], m_runs[CH], m_nt[CH];
    bit m_tick[CH], m_wave[CH];

    function automatic void mdl_reset();
        for (int i = 0; i < CH; i++) begin
            m_div[i] = DIV_INIT; m_mode[i] = 0; m_duty[i] = 0;
            m_runs[i] = 0; m_nt[i] = 0; m_tick[i] = 0; m_wave[i] = 0;
        end
    endfunction

    task automatic step(input logic [CH-1:0] r, input bit v, input int ch,
                        input int dv, input int md, input int dt);
        exp_t e;
        run      = r;
        ld_valid = v;
        ld_ch    = 2'(ch);
        bus.div  = CNT_W'(dv);
        bus.mode = 2'(md);
        ld_duty  = CNT_W'(dt);
        for (int i = 0; i < CH; i++) begin
            if (v && ch == i) begin
                m_div[i] = dv; m_mode[i] = md; m_duty[i] = dt;
                m_runs[i] = 0; m_nt[i] = 0; m_tick[i] = 0; m_wave[i] = 0;
            end else if (r[i]) begin
                int ph;
                m_runs[i]++;
                ph = m_runs[i] % (m_div[i] + 1);
                m_tick[i] = (ph == 0);
                if (m_tick[i]) m_nt[i]++;
                case (m_mode[i])
                    0:       m_wave[i] = m_nt[i][0];
                    1:       m_wave[i] = m_tick[i];
                    2:       m_wave[i] = PWM ? (ph < m_duty[i]) : 1'b0;
                    default: m_wave[i] = 1'b0;
                endcase
            end else begin
                m_tick[i] = 1'b0;
            end
        end
        e.cyc = cyc + 1;
        for (int i = 0; i < CH; i++) begin
            e.tick[i] = m_tick[i];
            e.wave[i] = m_wave[i];
        end
        q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n, input logic [CH-1:0] r);
        for (int k = 0; k < n; k++) step(r, 1'b0, 0, 0, 0, 0);
    endtask

    // Reset asserted mid-period; outputs must clear before the next edge.
    task automatic async_rst();
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        total++;
        if (tick !== '0 || wave !== '0) begin
            bad++;
            $display("FAIL async_rst tick=%b wave=%b want 0000/0000", tick, wave);
        end
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        mdl_reset();
    endtask

    // Monitor: compare every queued expectation whose cycle has arrived.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                total++;
                if (tick !== e.tick) begin
                    bad++;
                    $display("FAIL tick cyc=%0d got=%b want=%b", e.cyc, tick, e.tick);
                end
                total++;
                if (wave !== e.wave) begin
                    bad++;
                    $display("FAIL wave cyc=%0d got=%b want=%b", e.cyc, wave, e.wave);
                end
            end
        end
    end

    // Driver: directed scenarios, then randomized traffic.
    initial begin
        int n;
        RESET = 1'b1; run = '0; ld_valid = 1'b0; ld_ch = '0;
        bus.div = '0; bus.mode = '0; ld_duty = '0;
        mdl_reset();
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if (tick !== '0) begin bad++; $display("FAIL reset_tick got=%b want=0000", tick); end
        total++;
        if (wave !== '0) begin bad++; $display("FAIL reset_wave got=%b want=0000", wave); end
        RESET = 1'b0;

        idle(16, 4'hF);                       // div=3 default: tick every 4, wave period 8
        step(4'hF, 1'b1, 2, 0, 1, 0);         // ch2 div=0 PULSE
        idle(6, 4'hF);
        idle(2, 4'hF);
        step(4'hF, 1'b1, 1, 9, 0, 0);         // ch1 div=9 mid-period
        idle(12, 4'hF);
        idle(2, 4'hF);
        idle(5, 4'hE);                        // freeze ch0 for 5 cycles
        idle(10, 4'hF);
        step(4'hF, 1'b1, 3, 9, 2, 3);         // ch3 PWM duty 3 (or disabled mode 2)
        idle(22, 4'hF);
        step(4'hF, 1'b1, 3, 9, 2, 0);         // duty 0 -> low
        idle(12, 4'hF);
        step(4'hF, 1'b1, 3, 9, 2, 12);        // duty > div -> high
        idle(12, 4'hF);
        step(4'hF, 1'b1, 0, 2, 3, 0);         // reserved mode: wave 0, tick runs
        idle(8, 4'hF);
        idle(1, 4'hF);
        async_rst();
        idle(16, 4'hF);

        for (int k = 0; k < 800; k++) begin
            logic [CH-1:0] r;
            r = ($urandom % 4 == 0) ? CH'($urandom_range(0, 15)) : 4'hF;
            if ($urandom % 250 == 0) async_rst();
            step(r, ($urandom % 8 == 0), int'($urandom % 4), int'($urandom % 10),
                 int'($urandom % 4), int'($urandom % 13));
        end

        n = 0;
        while (q.size() > 0 && n < 5) begin
            @(posedge CLK);
            n++;
        end
        @(negedge CLK);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
